// File: rtl/gpu_pkg.sv
// Shared types for the GPU front end: vertex layout and dispatcher state encoding.
package gpu_pkg;

  typedef logic [2:0][31:0] vertex_t;

  localparam int WORDS_PER_TRI = 9;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    SWAP      = 3'd4
  } disp_state_t;

endpackage

// File: rtl/triangle_dispatcher_tri_fetch.sv
// Vertex RAM address sequencer and 9-word triangle capture register.
module tri_fetch
  import gpu_pkg::*;
#(
  parameter int VM_AW = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start,
  input  logic [VM_AW-1:0] base_addr,
  output logic             done,
  output logic [VM_AW-1:0] vm_addr,
  input  logic [31:0]      vm_rdata,
  output vertex_t          p1,
  output vertex_t          p2,
  output vertex_t          p3
);

  logic                                active_q;
  logic [3:0]                          k_q;
  logic [VM_AW-1:0]                    addr_q;
  logic [WORDS_PER_TRI-1:0][31:0]      w_q;

  // Cycle k issues address base+k; the word for address k lands one cycle later.
  // After the last issue the address simply holds, so the RAM sees no new traffic.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      active_q <= 1'b0;
      k_q      <= '0;
      addr_q   <= '0;
      w_q      <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      k_q      <= '0;
      addr_q   <= base_addr;
    end else if (active_q) begin
      if (k_q < 4'd8) addr_q <= addr_q + VM_AW'(1);
      for (int unsigned i = 0; i < WORDS_PER_TRI; i++) begin
        if (k_q == 4'(i + 1)) w_q[i] <= vm_rdata;
      end
      if (k_q == 4'd9) active_q <= 1'b0;
      else             k_q      <= k_q + 4'd1;
    end
  end

  assign done    = active_q && (k_q == 4'd9);
  assign vm_addr = addr_q;
  assign p1      = w_q[2:0];
  assign p2      = w_q[5:3];
  assign p3      = w_q[8:6];

endmodule

// File: rtl/triangle_dispatcher.sv
// Frame-level triangle dispatcher: fetches each triangle, hands it to the rasterizer, swaps buffers.
module triangle_dispatcher
  import gpu_pkg::*;
#(
  parameter int MAX_TRI    = 16,
  parameter int VM_AW      = 8,
  parameter int START_HOLD = 4,
  parameter int TIMEOUT    = 2**20
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             go,
  input  logic [7:0]       tri_count,
  output logic [VM_AW-1:0] vm_addr,
  input  logic [31:0]      vm_rdata,
  output vertex_t          p1,
  output vertex_t          p2,
  output vertex_t          p3,
  output logic             raster_start,
  input  logic             raster_done,
  output logic             buffer_sel,
  output logic             busy,
  output logic             frame_done,
  output logic             timeout_err
);

  localparam int TW = $clog2(MAX_TRI) + 1;
  localparam int HW = $clog2(START_HOLD) + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;

  disp_state_t      state_q;
  logic [TW-1:0]    n_q;
  logic [TW-1:0]    tri_idx_q;
  logic [HW-1:0]    hold_q;
  logic [WW-1:0]    wd_q;
  logic             raster_start_q;
  logic             buffer_sel_q;
  logic             frame_done_q;
  logic             timeout_err_q;

  logic [TW-1:0]    n_go;
  logic [TW-1:0]    next_idx;
  logic             last_tri;
  logic             fetch_start;
  logic             fetch_done;
  logic [VM_AW-1:0] base_addr;

  // The fetcher is kicked on the edge that enters FETCH, so its base address
  // is derived from the index the FSM is about to move to.
  always_comb begin
    n_go        = (int'(tri_count) > MAX_TRI) ? TW'(MAX_TRI) : TW'(tri_count);
    last_tri    = (tri_idx_q == n_q - TW'(1));
    next_idx    = (state_q == IDLE) ? '0 : tri_idx_q + TW'(1);
    fetch_start = ((state_q == IDLE) && go && (n_go != '0)) ||
                  ((state_q == WAIT_DONE) && raster_done && !last_tri);
    base_addr   = VM_AW'(32'(next_idx) * WORDS_PER_TRI);
  end

  tri_fetch #(
    .VM_AW (VM_AW)
  ) u_fetch (
    .clk       (clk),
    .areset_n  (areset_n),
    .start     (fetch_start),
    .base_addr (base_addr),
    .done      (fetch_done),
    .vm_addr   (vm_addr),
    .vm_rdata  (vm_rdata),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3)
  );

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q        <= IDLE;
      n_q            <= '0;
      tri_idx_q      <= '0;
      hold_q         <= '0;
      wd_q           <= '0;
      raster_start_q <= 1'b0;
      buffer_sel_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            n_q           <= n_go;
            tri_idx_q     <= '0;
            timeout_err_q <= 1'b0;
            if (n_go == '0) begin
              state_q      <= SWAP;
              frame_done_q <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          if (fetch_done) begin
            state_q        <= START;
            raster_start_q <= 1'b1;
            hold_q         <= '0;
          end
        end
        START: begin
          if (hold_q == HW'(START_HOLD - 1)) begin
            raster_start_q <= 1'b0;
            wd_q           <= '0;
            state_q        <= WAIT_DONE;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        WAIT_DONE: begin
          // Completion is checked before the watchdog so a coincident done is never an error.
          if (raster_done) begin
            tri_idx_q <= tri_idx_q + TW'(1);
            if (last_tri) begin
              state_q      <= SWAP;
              frame_done_q <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end else if (wd_q == WW'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            state_q       <= SWAP;
            frame_done_q  <= 1'b1;
          end else begin
            wd_q <= wd_q + WW'(1);
          end
        end
        SWAP: begin
          frame_done_q <= 1'b0;
          buffer_sel_q <= ~buffer_sel_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign raster_start = raster_start_q;
  assign buffer_sel   = buffer_sel_q;
  assign frame_done   = frame_done_q;
  assign timeout_err  = timeout_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Directed bench for triangle_dispatcher with a 1-cycle vertex RAM and a programmable-delay rasterizer.
module tb_triangle_dispatcher;

  typedef logic [2:0][31:0] vtx_t;

  logic        clk;
  logic        areset_n;
  logic        go;
  logic [7:0]  tri_count;
  logic [7:0]  vm_addr;
  logic [31:0] vm_rdata;
  vtx_t        p1, p2, p3;
  logic        raster_start;
  logic        raster_done;
  logic        buffer_sel;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] mem [0:255];

  // rasterizer model / monitor state
  int   d_tab [0:15];
  bit   never_done;
  bit   armed;
  int   wcnt;
  int   d_cur;
  logic rs_prev;
  int   rs_run;
  int   starts;
  int   fd_count;
  int   fd_cyc;
  int   go_cyc;
  logic [7:0] addr_prev;
  int   addr_log [$];
  int   hold_len [$];
  vtx_t s1 [$];
  vtx_t s2 [$];
  vtx_t s3 [$];

  triangle_dispatcher #(
    .MAX_TRI    (16),
    .VM_AW      (8),
    .START_HOLD (4),
    .TIMEOUT    (64)
  ) dut (
    .clk          (clk),
    .areset_n     (areset_n),
    .go           (go),
    .tri_count    (tri_count),
    .vm_addr      (vm_addr),
    .vm_rdata     (vm_rdata),
    .p1           (p1),
    .p2           (p2),
    .p3           (p3),
    .raster_start (raster_start),
    .raster_done  (raster_done),
    .buffer_sel   (buffer_sel),
    .busy         (busy),
    .frame_done   (frame_done),
    .timeout_err  (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) vm_rdata <= mem[vm_addr];

  // Rasterizer: raises done in the D-th cycle after raster_start falls (D=0 -> first WAIT cycle).
  always @(negedge clk) begin
    if (!areset_n) begin
      armed       = 1'b0;
      raster_done = 1'b0;
      rs_prev     = 1'b0;
      rs_run      = 0;
    end else begin
      if (raster_start && !rs_prev) begin
        starts++;
        s1.push_back(p1);
        s2.push_back(p2);
        s3.push_back(p3);
        d_cur = d_tab[(starts - 1) % 16];
      end
      if (raster_start) rs_run++;
      else if (rs_prev) begin
        hold_len.push_back(rs_run);
        rs_run = 0;
      end
      if (raster_start) begin
        armed = 1'b1;
        wcnt = 0;
        raster_done = 1'b0;
      end else if (armed && !never_done && wcnt == d_cur) begin
        raster_done = 1'b1;
        armed = 1'b0;
      end else begin
        raster_done = 1'b0;
        if (armed) wcnt++;
      end
      rs_prev = raster_start;
    end
    if (frame_done) begin
      fd_count++;
      fd_cyc = cyc;
    end
    if (vm_addr !== addr_prev) addr_log.push_back(int'(vm_addr));
    addr_prev = vm_addr;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    starts   = 0;
    fd_count = 0;
    addr_log.delete();
    hold_len.delete();
    s1.delete();
    s2.delete();
    s3.delete();
  endtask

  task automatic pulse_go(input int cnt);
    @(posedge clk); #1;
    tri_count = 8'(cnt);
    go = 1'b1;
    go_cyc = cyc;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (fd_count > 0) break;
      @(posedge clk);
    end
    chk("frame_seen", 96'(fd_count > 0), 96'(1));
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic vtx_t exp_v(input int t, input int v);
    vtx_t e;
    for (int c = 0; c < 3; c++) e[c] = mem[9 * t + 3 * v + c];
    return e;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int errs;
    vtx_t e;
    mem[0] = 32'h428a0000; mem[1] = 32'h428a0000; mem[2] = 32'h3f800000;
    mem[3] = 32'h43290000; mem[4] = 32'h428a0000; mem[5] = 32'h3f800000;
    mem[6] = 32'h428a0000; mem[7] = 32'h43290000; mem[8] = 32'h3f800000;
    for (int i = 9; i < 256; i++) mem[i] = 32'h4000_0000 | (i << 8) | i;
    for (int i = 0; i < 16; i++) d_tab[i] = 1;
    areset_n = 1'b0; go = 1'b0; tri_count = '0; raster_done = 1'b0;
    never_done = 1'b1; addr_prev = '0; d_cur = 0; wcnt = 0;
    clr();

    // 1: reset state, then an asynchronous reset while waiting on the rasterizer
    repeat (3) @(posedge clk); #1;
    areset_n = 1'b1;
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_raster_start", 96'(raster_start), 96'(0));
    chk("rst_buffer_sel", 96'(buffer_sel), 96'(0));
    chk("rst_vm_addr", 96'(vm_addr), 96'(0));
    chk("rst_frame_done", 96'(frame_done), 96'(0));
    pulse_go(1);
    repeat (20) @(posedge clk); #3;
    chk("wait_busy", 96'(busy), 96'(1));
    chk("wait_p1_loaded", 96'(p1), 96'({32'h3f800000, 32'h428a0000, 32'h428a0000}));
    areset_n = 1'b0; #1;
    chk("async_busy", 96'(busy), 96'(0));
    @(posedge clk); #1;
    areset_n = 1'b1;
    chk("rel_busy", 96'(busy), 96'(0));
    chk("rel_raster_start", 96'(raster_start), 96'(0));
    chk("rel_buffer_sel", 96'(buffer_sel), 96'(0));
    chk("rel_p1", 96'(p1), 96'(0));
    chk("rel_timeout_err", 96'(timeout_err), 96'(0));

    // 2: single triangle, D=5; frame_done 21 cycles after the go cycle (22 counted inclusively)
    never_done = 1'b0;
    d_tab[0] = 5;
    clr();
    pulse_go(1);
    wait_frame(200);
    chk("t2_starts", 96'(starts), 96'(1));
    chk("t2_p1x", 96'(s1[0][0]), 96'(32'h428a0000));
    chk("t2_p1y", 96'(s1[0][1]), 96'(32'h428a0000));
    chk("t2_p1z", 96'(s1[0][2]), 96'(32'h3f800000));
    chk("t2_p2", 96'(s2[0]), 96'({32'h3f800000, 32'h428a0000, 32'h43290000}));
    chk("t2_p3", 96'(s3[0]), 96'({32'h3f800000, 32'h43290000, 32'h428a0000}));
    chk("t2_hold", 96'(hold_len[0]), 96'(4));
    chk("t2_latency", 96'(fd_cyc - go_cyc), 96'(21));
    chk("t2_fd_count", 96'(fd_count), 96'(1));
    chk("t2_buffer_sel", 96'(buffer_sel), 96'(1));
    chk("t2_busy", 96'(busy), 96'(0));
    chk("t2_p1_held", 96'(p1), 96'(s1[0]));

    // 3: three triangles, D = 3,0,7
    d_tab[0] = 3; d_tab[1] = 0; d_tab[2] = 7;
    clr();
    pulse_go(3);
    wait_frame(400);
    chk("t3_starts", 96'(starts), 96'(3));
    for (int t = 0; t < 3; t++) begin
      chk($sformatf("t3_p1_tri%0d", t), 96'(s1[t]), 96'(exp_v(t, 0)));
      chk($sformatf("t3_p2_tri%0d", t), 96'(s2[t]), 96'(exp_v(t, 1)));
      chk($sformatf("t3_p3_tri%0d", t), 96'(s3[t]), 96'(exp_v(t, 2)));
    end
    chk("t3_addr_len", 96'(addr_log.size()), 96'(27));
    errs = 0;
    foreach (addr_log[i]) if (addr_log[i] != i) errs++;
    chk("t3_addr_seq_errs", 96'(errs), 96'(0));
    chk("t3_latency", 96'(fd_cyc - go_cyc), 96'(18 + 15 + 22 + 1));
    chk("t3_fd_count", 96'(fd_count), 96'(1));
    chk("t3_buffer_sel", 96'(buffer_sel), 96'(0));

    // 4: zero triangles
    clr();
    pulse_go(0);
    wait_frame(50);
    chk("t4_addr_activity", 96'(addr_log.size()), 96'(0));
    chk("t4_starts", 96'(starts), 96'(0));
    chk("t4_latency", 96'(fd_cyc - go_cyc), 96'(1));
    chk("t4_buffer_sel", 96'(buffer_sel), 96'(1));

    // 5: watchdog expiry on the first of two triangles (TIMEOUT=64)
    never_done = 1'b1;
    clr();
    pulse_go(2);
    wait_frame(300);
    chk("t5_timeout_err", 96'(timeout_err), 96'(1));
    chk("t5_starts", 96'(starts), 96'(1));
    chk("t5_addr_len", 96'(addr_log.size()), 96'(9));
    chk("t5_addr_last", 96'(addr_log[addr_log.size() - 1]), 96'(8));
    chk("t5_latency", 96'(fd_cyc - go_cyc), 96'(15 + 63 + 1));
    chk("t5_buffer_sel", 96'(buffer_sel), 96'(0));

    // 5b: done coincident with expiry (D=63) wins; the new go clears the error
    never_done = 1'b0;
    d_tab[0] = 63;
    clr();
    pulse_go(1);
    chk("t5b_err_cleared", 96'(timeout_err), 96'(0));
    wait_frame(300);
    chk("t5b_no_err", 96'(timeout_err), 96'(0));
    chk("t5b_latency", 96'(fd_cyc - go_cyc), 96'(15 + 63 + 1));
    chk("t5b_buffer_sel", 96'(buffer_sel), 96'(1));

    // 6: clamp 200 -> 16, extra go during FETCH and during SWAP is dropped
    for (int i = 0; i < 16; i++) d_tab[i] = 1;
    clr();
    pulse_go(200);
    @(posedge clk); #1;
    tri_count = 8'd5; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (cyc >= go_cyc + 257) break;
      @(posedge clk); #1;
    end
    chk("t6_in_swap_frame_done", 96'(frame_done), 96'(1));
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("t6_starts", 96'(starts), 96'(16));
    chk("t6_fd_count", 96'(fd_count), 96'(1));
    chk("t6_latency", 96'(fd_cyc - go_cyc), 96'(16 * 16 + 1));
    chk("t6_busy_after", 96'(busy), 96'(0));
    chk("t6_buffer_sel", 96'(buffer_sel), 96'(0));
    chk("t6_addr_len", 96'(addr_log.size()), 96'(144));
    errs = 0;
    foreach (addr_log[i]) if (addr_log[i] != i) errs++;
    chk("t6_addr_seq_errs", 96'(errs), 96'(0));
    errs = 0;
    foreach (hold_len[i]) if (hold_len[i] != 4) errs++;
    chk("t6_hold_errs", 96'(errs), 96'(0));
    e = exp_v(15, 2);
    chk("t6_last_p3", 96'(s3[15]), 96'(e));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
